// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter used as a timeout / interval source. Counts
//   qualified enable ticks from a loaded value down to zero and raises a
//   one-cycle underflow pulse on expiry. Supports one-shot and periodic
//   (auto-reload) operation and pause/resume.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | loaded or reset, waiting for start; enable ignored
//   RUN   | counting enable ticks down toward expiry
//   PAUSE | stopped mid-count, count held until start
//   DONE  | one-shot expired, count is 0; start reloads from reload_reg
//
//   Per-cycle priority: load > stop > start > tick.

module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_nxt;
  logic             underflow_nxt;

  logic             tick;
  logic             count_zero;
  logic             count_one;
  logic             reload_zero;
  logic             load_value_zero;

  // Condition decode shared by the next-state logic.
  always_comb begin
    tick            = (state == RUN) && enable && !load && !stop;
    count_zero      = (count == ZERO);
    count_one       = (count == ONE);
    reload_zero     = (reload_reg == ZERO);
    load_value_zero = (load_value == ZERO);
  end

  // Next-state, count and reload computation in priority order.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    reload_nxt    = reload_reg;
    underflow_nxt = 1'b0;

    if (load) begin
      // A load always re-arms; starting on a zero value would expire
      // without any tick, so that case stays idle.
      count_nxt  = load_value;
      reload_nxt = load_value;
      state_nxt  = (start && !load_value_zero) ? RUN : IDLE;
    end else if (stop) begin
      // Stop wins over a coincident tick, including one that would expire.
      if (state == RUN) begin
        state_nxt = PAUSE;
      end
    end else begin
      if (start) begin
        case (state)
          IDLE, PAUSE: begin
            if (!count_zero) begin
              state_nxt = RUN;
            end
          end
          DONE: begin
            if (!reload_zero) begin
              state_nxt = RUN;
              count_nxt = reload_reg;
            end
          end
          default: begin
            // RUN: start has no effect, a tick may still occur below.
          end
        endcase
      end

      if (tick) begin
        if (count_one) begin
          underflow_nxt = 1'b1;
          if (periodic) begin
            count_nxt = reload_reg;
          end else begin
            count_nxt = ZERO;
            state_nxt = DONE;
          end
        end else if (!count_zero) begin
          count_nxt = count - ONE;
        end
        // A zero count in RUN is unreachable; holding avoids any wrap.
      end
    end
  end

  // State, count, reload value and underflow pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      underflow  <= underflow_nxt;
    end
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule
